sc_stream_argmax_decoder: RTL and testbench
===========================================

SC_STREAM_ARGMAX_DECODER -- requirements
Module: sc_stream_argmax_decoder

Interface
REQ-001 SHALL have parameter N, default 10: number of stochastic output streams (classes) decoded.
REQ-002 SHALL have parameter L, default 8: the decode window is 2^L valid samples.
REQ-003 SHALL have parameter IW, default 4: class index width; the instantiator guarantees 2^IW >= N.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: request a new decode window.
REQ-007 SHALL have port din, input, N: one stochastic bit per class stream per cycle, taken from the network output layer.
REQ-008 SHALL have port din_valid, input, 1: qualifies din for the current cycle.
REQ-009 SHALL have port busy, output, 1: high while a window is being accumulated or scanned.
REQ-010 SHALL have port done, output, 1: single-cycle pulse when a result is published.
REQ-011 SHALL have port class_idx, output, IW: index of the stream with the highest ones-count.
REQ-012 SHALL have port class_count, output, L+1: ones-count of the winning stream.
REQ-013 SHALL have port tie, output, 1: asserted when more than one stream holds the maximum count.

Function
REQ-014 SHALL implement the FSM states IDLE, ACCUM, SCAN and DONE.
REQ-015 SHALL accept start in IDLE or DONE, then move to ACCUM next cycle, clearing all N stream counters and the sample counter.
REQ-016 SHALL ignore start in ACCUM and SCAN, with no effect on counters or outputs.
REQ-017 In ACCUM, each cycle with din_valid=1 SHALL increment the sample counter and increment counter i for each set din[i]; cycles with din_valid=0 SHALL change nothing.
REQ-018 SHALL use stream counters L+1 bits wide, so an all-ones stream reaches exactly 2^L without wrap.
REQ-019 SHALL go from ACCUM to SCAN on the cycle that accepts the 2^L-th valid sample, with that sample counted.
REQ-020 In SCAN, SHALL compare one stream per cycle, index 0 to N-1 (N cycles), tracking the running maximum, its index and a tie flag.
REQ-021 On a strict greater-than compare, SHALL replace the maximum and clear tie; on an equal compare, SHALL keep the lower index and set tie.
REQ-022 After the stream N-1 compare, SHALL enter DONE; on that transition, SHALL register class_idx, class_count and tie.
REQ-023 SHALL assert done only in DONE, for exactly one cycle; DONE SHALL return to IDLE unless start is accepted, in which case it goes to ACCUM.
REQ-024 SHALL hold class_idx, class_count and tie from DONE until the next DONE or reset.
REQ-025 SHALL drive busy=1 in ACCUM and SCAN, and busy=0 in IDLE and DONE.
REQ-026 Latency: with start accepted at cycle t and din_valid continuously high, done SHALL assert at cycle t+2^L+N+1; each cycle with din_valid=0 SHALL add one cycle.
REQ-027 If all counts are zero, the result SHALL be class_idx=0, class_count=0, tie=1 (for N>1).

Reset
REQ-028 When reset=1 at a clock edge, SHALL force IDLE and set busy=0, done=0, class_idx=0, class_count=0, tie=0, with all counters cleared.
REQ-029 Reset SHALL take priority over start and din_valid in the same cycle.
REQ-030 Reset during ACCUM or SCAN SHALL abort the window, produce no done pulse, and lose the partial counts.

Verification (N=10, L=4, IW=4)
REQ-031 SHALL cover: reset held 2 cycles -> busy=0, done=0, class_idx=0, class_count=0, tie=0.
REQ-032 SHALL cover: start at t, din_valid=1, din[7]=1 always, other streams 0 -> done at t+27, class_idx=7, class_count=16, tie=0.
REQ-033 SHALL cover: streams 2 and 5 each with 12 ones, others at most 9 -> class_idx=2, class_count=12, tie=1.
REQ-034 SHALL cover: din_valid alternating 1/0 from t+1, din=all-ones on invalid cycles, din[3]=1 only on valid cycles -> done at t+43, class_idx=3, class_count=16.
REQ-035 SHALL cover: reset pulsed at t+8 in ACCUM -> busy=0 at t+9, no done; a new start gives a correct, fresh result.
REQ-036 SHALL cover: start held high through ACCUM/SCAN -> ignored, counts unaffected; start held high in the DONE cycle -> ACCUM next cycle, busy=1, and a second result follows at the nominal latency.

Source files
------------

// File: rtl/sc_stream_argmax_decoder_if.sv
// Stream-side bundle for the stochastic argmax decoder: sample input plus
// the published result.
interface sc_stream_argmax_decoder_if #(
  parameter int N  = 10,
  parameter int L  = 8,
  parameter int IW = 4
);
  logic          start;
  logic [N-1:0]  din;
  logic          din_valid;
  logic          busy;
  logic          done;
  logic [IW-1:0] class_idx;
  logic [L:0]    class_count;
  logic          tie;

  modport master (
    output start, din, din_valid,
    input  busy, done, class_idx, class_count, tie
  );

  modport slave (
    input  start, din, din_valid,
    output busy, done, class_idx, class_count, tie
  );
endinterface

// File: rtl/sc_stream_argmax_decoder.sv
// Counts ones on N stochastic streams over a 2^L-sample window, then scans the
// counters one per cycle to publish the winning class, its count and a tie flag.
module sc_stream_argmax_decoder #(
  parameter int N  = 10,
  parameter int L  = 8,
  parameter int IW = 4
) (
  input logic                       clk,
  input logic                       reset,
  sc_stream_argmax_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;

  state_t        state;
  state_t        state_next;

  logic [L:0]    cnt [N];
  logic [L-1:0]  sample_cnt;
  logic [IW-1:0] scan_idx;

  logic [L:0]    max_cnt;
  logic [IW-1:0] max_idx;
  logic          max_tie;

  logic [L:0]    scan_val;
  logic [L:0]    max_next;
  logic [IW-1:0] idx_next;
  logic          tie_next;

  logic [IW-1:0] class_idx_r;
  logic [L:0]    class_count_r;
  logic          tie_r;

  logic          start_ok;
  logic          last_sample;
  logic          last_scan;

  assign start_ok    = bus.start && ((state == IDLE) || (state == DONE));
  assign last_sample = (state == ACCUM) && bus.din_valid && (sample_cnt == '1);
  assign last_scan   = (state == SCAN) && (scan_idx == IW'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_next = ACCUM;
      end
      ACCUM: begin
        bus.busy = 1'b1;
        if (last_sample) state_next = SCAN;
      end
      SCAN: begin
        bus.busy = 1'b1;
        if (last_scan) state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = start_ok ? ACCUM : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stream 0 seeds the running maximum; equal later counts keep the lower index.
  always_comb begin
    scan_val = '0;
    for (int i = 0; i < N; i++) begin
      if (scan_idx == IW'(i)) scan_val = cnt[i];
    end
    max_next = max_cnt;
    idx_next = max_idx;
    tie_next = max_tie;
    if (scan_idx == '0) begin
      max_next = scan_val;
      idx_next = '0;
      tie_next = 1'b0;
    end else if (scan_val > max_cnt) begin
      max_next = scan_val;
      idx_next = scan_idx;
      tie_next = 1'b0;
    end else if (scan_val == max_cnt) begin
      tie_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
      sample_cnt    <= '0;
      scan_idx      <= '0;
      max_cnt       <= '0;
      max_idx       <= '0;
      max_tie       <= 1'b0;
      class_idx_r   <= '0;
      class_count_r <= '0;
      tie_r         <= 1'b0;
    end else if (start_ok) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
      sample_cnt <= '0;
      scan_idx   <= '0;
    end else if (state == ACCUM) begin
      if (bus.din_valid) begin
        for (int i = 0; i < N; i++) cnt[i] <= cnt[i] + {{L{1'b0}}, bus.din[i]};
        sample_cnt <= sample_cnt + 1'b1;
      end
    end else if (state == SCAN) begin
      max_cnt  <= max_next;
      max_idx  <= idx_next;
      max_tie  <= tie_next;
      scan_idx <= scan_idx + 1'b1;
      if (last_scan) begin
        class_idx_r   <= idx_next;
        class_count_r <= max_next;
        tie_r         <= tie_next;
      end
    end
  end

  assign bus.class_idx   = class_idx_r;
  assign bus.class_count = class_count_r;
  assign bus.tie         = tie_r;

endmodule

// File: tb/tb_sc_stream_argmax_decoder.sv
// Directed, table-driven bench for sc_stream_argmax_decoder with N=10, L=4, IW=4,
// plus hand-written reset-abort and held-start sequences.
module tb_sc_stream_argmax_decoder;
  localparam int N      = 10;
  localparam int L      = 4;
  localparam int IW     = 4;
  localparam int WIN    = 1 << L;
  localparam int BUDGET = 200;
  localparam int NVEC   = 9;

  typedef struct {
    logic [N-1:0][L:0] counts;
    bit                gap;
    logic [IW-1:0]     exp_idx;
    logic [L:0]        exp_count;
    logic              exp_tie;
    int                exp_lat;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   prev_idx, prev_count, prev_tie;
  rec_t vecs [NVEC];
  rec_t extra;

  always #5 clk = ~clk;

  sc_stream_argmax_decoder_if #(.N(N), .L(L), .IW(IW)) bus ();

  sc_stream_argmax_decoder #(.N(N), .L(L), .IW(IW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [N-1:0][L:0] mk(input int c0, c1, c2, c3, c4,
                                           input int c5, c6, c7, c8, c9);
    logic [N-1:0][L:0] v;
    v[0] = (L+1)'(c0); v[1] = (L+1)'(c1); v[2] = (L+1)'(c2); v[3] = (L+1)'(c3);
    v[4] = (L+1)'(c4); v[5] = (L+1)'(c5); v[6] = (L+1)'(c6); v[7] = (L+1)'(c7);
    v[8] = (L+1)'(c8); v[9] = (L+1)'(c9);
    return v;
  endfunction

  function automatic rec_t mkrec(input logic [N-1:0][L:0] c, input bit gap,
                                 input int idx, input int cnt, input int t, input int lat);
    rec_t r;
    r.counts    = c;
    r.gap       = gap;
    r.exp_idx   = IW'(idx);
    r.exp_count = (L+1)'(cnt);
    r.exp_tie   = t[0];
    r.exp_lat   = lat;
    return r;
  endfunction

  // Start a window (start high in the current cycle), feed samples, wait for done.
  task automatic apply_stimulus(input rec_t r, input bit hold);
    int k = 0;
    int n = 1;
    bit seen = 0;
    bit invalid_phase;
    invalid_phase = r.gap;
    bus.start     = 1'b1;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    tick();
    if (!hold) bus.start = 1'b0;
    check_output("busy_after_start", bus.busy, 1);
    check_output("held_idx", bus.class_idx, prev_idx);
    check_output("held_count", bus.class_count, prev_count);
    while (n < BUDGET && !seen) begin
      if (k < WIN && invalid_phase) begin
        bus.din_valid = 1'b0;
        bus.din       = '1;
      end else if (k < WIN) begin
        bus.din_valid = 1'b1;
        for (int i = 0; i < N; i++) bus.din[i] = (k < int'(r.counts[i]));
        k++;
      end else begin
        bus.din_valid = 1'b0;
        bus.din       = '0;
      end
      if (r.gap) invalid_phase = !invalid_phase;
      tick();
      n++;
      if (bus.done) seen = 1;
    end
    bus.din_valid = 1'b0;
    bus.din       = '0;
    check_output("done_seen", int'(seen), 1);
    check_output("latency", n, r.exp_lat);
    check_output("busy_in_done", bus.busy, 0);
    check_output("class_idx", bus.class_idx, r.exp_idx);
    check_output("class_count", bus.class_count, r.exp_count);
    check_output("tie", bus.tie, r.exp_tie);
    prev_idx   = r.exp_idx;
    prev_count = r.exp_count;
    prev_tie   = r.exp_tie;
  endtask

  task automatic post_done_check();
    bus.start = 1'b0;
    tick();
    check_output("done_one_cycle", bus.done, 0);
    check_output("busy_idle", bus.busy, 0);
    check_output("hold_idx", bus.class_idx, prev_idx);
    check_output("hold_tie", bus.tie, prev_tie);
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_busy"}, bus.busy, 0);
    check_output({tag, "_done"}, bus.done, 0);
    check_output({tag, "_idx"}, bus.class_idx, 0);
    check_output({tag, "_count"}, bus.class_count, 0);
    check_output({tag, "_tie"}, bus.tie, 0);
  endtask

  initial begin
    int done_hits;
    vecs[0] = mkrec(mk(0, 0, 0, 0, 0, 0, 0, 16, 0, 0),  0, 7, 16, 0, 27);
    vecs[1] = mkrec(mk(3, 9, 12, 0, 7, 12, 1, 9, 4, 2), 0, 2, 12, 1, 27);
    vecs[2] = mkrec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0),   0, 0, 0,  1, 27);
    vecs[3] = mkrec(mk(15, 0, 0, 0, 0, 0, 0, 0, 0, 16), 0, 9, 16, 0, 27);
    vecs[4] = mkrec(mk(5, 4, 4, 4, 4, 4, 4, 4, 4, 4),   0, 0, 5,  0, 27);
    vecs[5] = mkrec(mk(16, 16, 16, 16, 16, 16, 16, 16, 16, 16), 0, 0, 16, 1, 27);
    vecs[6] = mkrec(mk(0, 8, 0, 8, 0, 0, 10, 0, 0, 0),  0, 6, 10, 0, 27);
    vecs[7] = mkrec(mk(0, 0, 0, 16, 0, 0, 0, 0, 0, 0),  1, 3, 16, 0, 43);
    vecs[8] = mkrec(mk(1, 2, 3, 4, 5, 6, 7, 8, 9, 10),  1, 9, 10, 0, 43);

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    prev_idx      = 0;
    prev_count    = 0;
    prev_tie      = 0;
    tick();
    tick();
    check_reset_state("reset");
    reset = 1'b0;
    tick();

    for (int v = 0; v < NVEC; v++) begin
      $display("[TB] vector %0d", v);
      apply_stimulus(vecs[v], 1'b0);
      post_done_check();
    end

    // Reset in the middle of accumulation aborts the window and clears results.
    $display("[TB] reset abort sequence");
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int j = 1; j < 8; j++) begin
      bus.din_valid = 1'b1;
      bus.din       = '0;
      bus.din[4]    = 1'b1;
      tick();
    end
    check_output("busy_before_abort", bus.busy, 1);
    reset = 1'b1;
    tick();
    reset         = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    check_reset_state("abort");
    prev_idx   = 0;
    prev_count = 0;
    prev_tie   = 0;
    done_hits  = 0;
    for (int j = 0; j < 30; j++) begin
      tick();
      if (bus.done) done_hits++;
    end
    check_output("no_done_after_abort", done_hits, 0);
    extra = mkrec(mk(0, 5, 0, 0, 3, 0, 0, 0, 0, 0), 0, 1, 5, 0, 27);
    apply_stimulus(extra, 1'b0);
    post_done_check();

    // Start held high across two windows: ignored while busy, accepted in DONE.
    $display("[TB] held start sequence");
    apply_stimulus(vecs[0], 1'b1);
    extra = mkrec(mk(0, 0, 16, 0, 0, 0, 0, 3, 0, 0), 0, 2, 16, 0, 27);
    apply_stimulus(extra, 1'b1);
    post_done_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
